// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece controller: piece codes, sequencer states
// and the LFSR-to-piece mapping.
package tetris_pkg;

    localparam int PIECE_W = 3;

    typedef enum logic [PIECE_W-1:0] {
        P_LINE     = 3'd0,
        P_SMASHBOY = 3'd1,
        P_L        = 3'd2,
        P_REV_L    = 3'd3,
        P_S        = 3'd4,
        P_Z        = 3'd5,
        P_T        = 3'd6
    } piece_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_SPAWN_CHK,
        S_FALL,
        S_LOCK,
        S_CLEAR,
        S_GAME_OVER
    } seq_state_t;

    // Code 7 is not a piece: fall back to the next field, then to LINE.
    function automatic piece_t lfsr_to_piece(input logic [6:0] state);
        if (state[2:0] != 3'd7)
            return piece_t'(state[2:0]);
        else if (state[5:3] != 3'd7)
            return piece_t'(state[5:3]);
        else
            return P_LINE;
    endfunction

endpackage

// File: rtl/piece_lfsr.sv
// 7-bit Fibonacci LFSR (x^7 + x^6 + 1) that proposes the next piece and
// advances only when a piece is actually spawned.
module piece_lfsr
    import tetris_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   advance,
    output piece_t next_piece
);

    logic [6:0] lfsr;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; a blocking = here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= SEED;
        else if (advance)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end

    assign next_piece = lfsr_to_piece(lfsr);

endmodule

// File: rtl/drop_sequencer.sv
// Game-level controller for the falling piece: spawn, gravity pacing, landing,
// lock/clear handshake, line/level bookkeeping and game-over detection.
module drop_sequencer
    import tetris_pkg::*;
#(
    parameter int         TICK_W          = 26,
    parameter int         GRAV_BASE       = 25_000_000,
    parameter int         GRAV_STEP       = 2_000_000,
    parameter int         GRAV_MIN        = 2_500_000,
    parameter int         SOFT_PERIOD     = 2_500_000,
    parameter int         LINES_PER_LEVEL = 10,
    parameter logic [6:0] LFSR_SEED       = 7'h5A
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               soft_drop,
    input  logic               step_done,
    input  logic               spawn_blocked,
    input  logic               clear_done,
    input  logic [2:0]         lines_cleared,
    output logic [PIECE_W-1:0] piece_type,
    output logic               piece_valid,
    output logic               step_en,
    output logic               lock_en,
    output logic               clear_req,
    output logic [15:0]        lines_total,
    output logic [3:0]         level,
    output logic               game_over
);

    localparam logic [31:0] BASE_P = 32'(GRAV_BASE);
    localparam logic [31:0] STEP_P = 32'(GRAV_STEP);
    localparam logic [31:0] MIN_P  = 32'(GRAV_MIN);
    localparam logic [31:0] SOFT_P = 32'(SOFT_PERIOD);
    localparam logic [7:0]  LPL    = 8'(LINES_PER_LEVEL);

    seq_state_t        state;
    logic [TICK_W-1:0] tick;
    logic [7:0]        lines_left;
    piece_t            next_piece;

    logic [31:0] level_drop;
    logic [31:0] grav;
    logic [31:0] period;
    logic        tick_hit;
    logic [2:0]  lines_eff;
    logic [16:0] lines_sum;

    piece_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .advance    (state == S_SPAWN),
        .next_piece (next_piece)
    );

    // NOTE: every always_comb output gets a value on every path; a missing
    // default would infer a latch.
    always_comb begin
        level_drop = {28'd0, level} * STEP_P;
        grav       = BASE_P - level_drop;
        // Clamp before the subtraction can underflow at high levels.
        if (level_drop + MIN_P >= BASE_P)
            grav = MIN_P;
        period = grav;
        if (soft_drop && SOFT_P < grav)
            period = SOFT_P;
        tick_hit  = {{(32-TICK_W){1'b0}}, tick} >= period - 32'd1;
        lines_eff = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
        lines_sum = {1'b0, lines_total} + {14'd0, lines_eff};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            tick        <= '0;
            lines_left  <= LPL;
            piece_type  <= '0;
            piece_valid <= 1'b0;
            step_en     <= 1'b0;
            lock_en     <= 1'b0;
            clear_req   <= 1'b0;
            lines_total <= '0;
            level       <= '0;
            game_over   <= 1'b0;
        end else begin
            step_en <= 1'b0;
            lock_en <= 1'b0;
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        state       <= S_SPAWN;
                        tick        <= '0;
                        lines_left  <= LPL;
                        lines_total <= '0;
                        level       <= '0;
                        game_over   <= 1'b0;
                    end
                end
                S_SPAWN: begin
                    piece_type <= next_piece;
                    state      <= S_SPAWN_CHK;
                end
                S_SPAWN_CHK: begin
                    if (spawn_blocked) begin
                        state     <= S_GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state       <= S_FALL;
                        tick        <= '0;
                        piece_valid <= 1'b1;
                    end
                end
                S_FALL: begin
                    if (tick_hit) begin
                        tick <= '0;
                        if (step_done) begin
                            state       <= S_LOCK;
                            lock_en     <= 1'b1;
                            piece_valid <= 1'b0;
                        end else begin
                            step_en <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_LOCK: begin
                    clear_req <= 1'b1;
                    state     <= S_CLEAR;
                end
                S_CLEAR: begin
                    if (clear_done) begin
                        clear_req   <= 1'b0;
                        state       <= S_SPAWN;
                        lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
                        // One level per clear at most, even on a multi-line crossing.
                        if ({5'd0, lines_eff} >= lines_left) begin
                            lines_left <= LPL;
                            if (level != 4'd15)
                                level <= level + 4'd1;
                        end else begin
                            lines_left <= lines_left - {5'd0, lines_eff};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer with shortened gravity periods
// (base 8, step 2, floor 3, soft 4).
module tb_drop_sequencer;
    import tetris_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         soft_drop = 1'b0;
    logic         step_done = 1'b0;
    logic         spawn_blocked = 1'b0;
    logic         clear_done = 1'b0;
    logic [2:0]   lines_cleared = 3'd0;
    logic [2:0]   piece_type;
    logic         piece_valid;
    logic         step_en;
    logic         lock_en;
    logic         clear_req;
    logic [15:0]  lines_total;
    logic [3:0]   level;
    logic         game_over;

    int checks = 0;
    int errors = 0;
    bit seen [0:7];

    drop_sequencer #(
        .TICK_W          (8),
        .GRAV_BASE       (8),
        .GRAV_STEP       (2),
        .GRAV_MIN        (3),
        .SOFT_PERIOD     (4),
        .LINES_PER_LEVEL (10),
        .LFSR_SEED       (7'h5A)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .soft_drop     (soft_drop),
        .step_done     (step_done),
        .spawn_blocked (spawn_blocked),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared),
        .piece_type    (piece_type),
        .piece_valid   (piece_valid),
        .step_en       (step_en),
        .lock_en       (lock_en),
        .clear_req     (clear_req),
        .lines_total   (lines_total),
        .level         (level),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_piece_type"},  32'(piece_type),  32'd0);
        check({tag, "_piece_valid"}, 32'(piece_valid), 32'd0);
        check({tag, "_step_en"},     32'(step_en),     32'd0);
        check({tag, "_lock_en"},     32'(lock_en),     32'd0);
        check({tag, "_clear_req"},   32'(clear_req),   32'd0);
        check({tag, "_lines_total"}, 32'(lines_total), 32'd0);
        check({tag, "_level"},       32'(level),       32'd0);
        check({tag, "_game_over"},   32'(game_over),   32'd0);
    endtask

    // Expects step_en low for (period-1) cycles and high on the period-th.
    task automatic expect_period(input string tag, input int period);
        for (int i = 0; i < period - 1; i++) begin
            tk();
            check({tag, "_quiet"}, 32'(step_en), 32'd0);
        end
        tk();
        check({tag, "_pulse"}, 32'(step_en), 32'd1);
    endtask

    // From FALL: land the piece and complete the clear; ends one edge after
    // clear_done is accepted (sequencer then in SPAWN).
    task automatic land_and_clear(input logic [2:0] lines);
        bit found = 1'b0;
        step_done = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            tk();
            if (lock_en) found = 1'b1;
        end
        check("lock_seen", 32'(found), 32'd1);
        step_done = 1'b0;
        tk();
        check("clear_req_up", 32'(clear_req), 32'd1);
        clear_done    = 1'b1;
        lines_cleared = lines;
        tk();
        clear_done    = 1'b0;
        lines_cleared = 3'd0;
        check("clear_req_drop", 32'(clear_req), 32'd0);
    endtask

    initial begin
        // Reset state
        tk();
        check_all_zero("reset");
        rst = 1'b1;
        tk();
        check_all_zero("idle");

        // Start: piece_valid two edges after start is taken
        start = 1'b1;
        tk();
        start = 1'b0;
        tk();
        check("first_piece", 32'(piece_type), 32'd2);
        check("valid_not_yet", 32'(piece_valid), 32'd0);
        tk();
        check("valid_in_fall", 32'(piece_valid), 32'd1);

        // Gravity at level 0: one step every 8 cycles
        expect_period("grav8_a", 8);
        clear_done    = 1'b1;
        lines_cleared = 3'd3;
        expect_period("grav8_b", 8);
        clear_done    = 1'b0;
        lines_cleared = 3'd0;
        check("clear_done_ignored", 32'(lines_total), 32'd0);

        // Landing: no step, lock one cycle later, clear_req held
        step_done = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tk();
            check("land_wait_step", 32'(step_en), 32'd0);
        end
        tk();
        check("land_lock_en", 32'(lock_en), 32'd1);
        check("land_no_step", 32'(step_en), 32'd0);
        check("land_valid_low", 32'(piece_valid), 32'd0);
        step_done = 1'b0;
        tk();
        check("lock_pulse_end", 32'(lock_en), 32'd0);
        check("clear_req_set", 32'(clear_req), 32'd1);
        tk();
        tk();
        check("clear_req_hold", 32'(clear_req), 32'd1);
        clear_done    = 1'b1;
        lines_cleared = 3'd4;
        tk();
        clear_done    = 1'b0;
        lines_cleared = 3'd0;
        check("clear_req_release", 32'(clear_req), 32'd0);
        check("lines_4", 32'(lines_total), 32'd4);
        tk();
        tk();

        // Two more 4-line clears: 12 lines, level 1
        land_and_clear(3'd4);
        check("lines_8", 32'(lines_total), 32'd8);
        check("level_0", 32'(level), 32'd0);
        tk();
        tk();
        land_and_clear(3'd4);
        check("lines_12", 32'(lines_total), 32'd12);
        check("level_1", 32'(level), 32'd1);
        tk();
        tk();
        check("refall_valid", 32'(piece_valid), 32'd1);

        // Level 1 gravity is 6, soft drop caps it at 4
        expect_period("grav6", 6);
        soft_drop = 1'b1;
        expect_period("soft4", 4);
        soft_drop = 1'b0;

        // Oversized lines_cleared counts as 4
        land_and_clear(3'd7);
        check("lines_clamp", 32'(lines_total), 32'd16);
        check("level_hold", 32'(level), 32'd1);

        // Blocked spawn: game over is sticky and keeps the score
        spawn_blocked = 1'b1;
        tk();
        tk();
        check("game_over_set", 32'(game_over), 32'd1);
        check("game_over_novalid", 32'(piece_valid), 32'd0);
        check("game_over_lines", 32'(lines_total), 32'd16);
        tk();
        tk();
        check("game_over_sticky", 32'(game_over), 32'd1);

        // Restart clears the counters
        spawn_blocked = 1'b0;
        start = 1'b1;
        tk();
        start = 1'b0;
        check("restart_go", 32'(game_over), 32'd0);
        check("restart_lines", 32'(lines_total), 32'd0);
        check("restart_level", 32'(level), 32'd0);
        tk();
        tk();
        check("restart_valid", 32'(piece_valid), 32'd1);
        start = 1'b1;
        expect_period("restart_grav8", 8);
        start = 1'b0;
        check("start_ignored_in_fall", 32'(piece_valid), 32'd1);

        // Asynchronous reset mid-FALL
        tk();
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tk();
        check_all_zero("rst_edge");
        rst = 1'b1;
        tk();
        check("post_rst_idle", 32'(piece_valid), 32'd0);

        // 1000 spawns from the seed: codes always legal, all seven appear
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        start = 1'b1;
        spawn_blocked = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            tk();
            tk();
            check("spawn_range", 32'(piece_type <= 3'd6), 32'd1);
            if (n == 0) check("spawn_first_after_rst", 32'(piece_type), 32'd2);
            seen[piece_type] = 1'b1;
            tk();
        end
        start = 1'b0;
        spawn_blocked = 1'b0;
        for (int i = 0; i < 7; i++)
            check($sformatf("piece_seen_%0d", i), 32'(seen[i]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
